// File: rtl/pico_soc_pkg.sv
// pico_soc_pkg: shared bridge state encoding, peripheral window base and timeout read value
package pico_soc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    localparam logic [31:0] PBASE_DEF = 32'h0200_0000;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/wb_addr_dec.sv
// wb_addr_dec: peripheral window match and slave index decode
module wb_addr_dec import pico_soc_pkg::*; #(
    parameter int NSLV = 4,
    parameter logic [31:0] PBASE = PBASE_DEF,
    parameter int IW = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [IW-1:0] index
);
    logic unused_ok;
    assign hit = addr[31:16] == PBASE[31:16];
    assign index = (NSLV > 1) ? addr[8 +: IW] : '0;
    assign unused_ok = ^addr;
endmodule

// File: rtl/pico2wb_bridge.sv
// pico2wb_bridge: PicoRV32 native bus to multi-slave Wishbone bridge with ack timeout
module pico2wb_bridge import pico_soc_pkg::*; #(
    parameter int NSLV = 4,
    parameter int ASIZE = 2,
    parameter int DSIZE = 8,
    parameter logic [31:0] PBASE = PBASE_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mem_valid,
    input  logic [31:0]           i_mem_addr,
    input  logic [31:0]           i_mem_wdata,
    input  logic [3:0]            i_mem_wstrb,
    output logic                  o_mem_ready,
    output logic [31:0]           o_mem_rdata,
    output logic                  o_err,
    output logic [NSLV-1:0]       o_wb_stb,
    output logic [ASIZE-1:0]      o_wb_adr,
    output logic                  o_wb_we,
    output logic [DSIZE-1:0]      o_wb_dat,
    input  logic [NSLV-1:0]       i_wb_ack,
    input  logic [NSLV*DSIZE-1:0] i_wb_dat
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_nxt;
    logic [IW-1:0] idx, dec_idx;
    logic [CW-1:0] cnt;
    logic [31:0] rdata_q;
    logic err_q, win_hit, hit, ack_sel, timed_out, unused_ok;
    logic [DSIZE-1:0] sel_dat;

    wb_addr_dec #(.NSLV(NSLV), .PBASE(PBASE), .IW(IW)) u_dec (
        .addr  (i_mem_addr),
        .hit   (win_hit),
        .index (dec_idx)
    );

    assign hit = i_mem_valid & win_hit;
    assign ack_sel = i_wb_ack[idx];
    assign sel_dat = i_wb_dat[idx*DSIZE +: DSIZE];
    // counter reaches TIMEOUT at the end of the TIMEOUT-th strobe cycle
    assign timed_out = cnt == CW'(TIMEOUT - 1);
    assign o_mem_rdata = rdata_q;
    assign unused_ok = ^{i_mem_addr, i_mem_wdata};

    always_comb begin
        state_nxt = state;
        o_wb_stb = (state == S_REQ) ? NSLV'(1) << idx : '0;
        o_mem_ready = state == S_RESP;
        o_err = (state == S_RESP) & err_q;
        case (state)
            S_IDLE:  state_nxt = hit ? S_REQ : S_IDLE;
            S_REQ:   state_nxt = (ack_sel || timed_out) ? S_RESP : S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            idx <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_we <= 1'b0;
            cnt <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && hit) begin
                idx <= dec_idx;
                o_wb_adr <= i_mem_addr[ASIZE+1:2];
                o_wb_dat <= i_mem_wdata[DSIZE-1:0];
                o_wb_we <= |i_mem_wstrb;
                cnt <= '0;
            end
            if (state == S_REQ) begin
                cnt <= cnt + CW'(1);
                if (ack_sel) begin
                    rdata_q <= o_wb_we ? '0 : 32'(sel_dat);
                    err_q <= 1'b0;
                end else if (timed_out) begin
                    rdata_q <= TIMEOUT_RDATA;
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pico2wb_bridge.sv
// tb_pico2wb_bridge: directed and random transfers checked against a transaction-level model
module tb_pico2wb_bridge;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata, sdat = '0;
    logic [3:0] wstrb = '0, stb, ack = '0;
    logic ready, err, we;
    logic [1:0] adr;
    logic [7:0] dat;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    pico2wb_bridge #(.NSLV(4), .ASIZE(2), .DSIZE(8), .PBASE(32'h0200_0000), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mem_valid (valid),
        .i_mem_addr  (addr),
        .i_mem_wdata (wdata),
        .i_mem_wstrb (wstrb),
        .o_mem_ready (ready),
        .o_mem_rdata (rdata),
        .o_err       (err),
        .o_wb_stb    (stb),
        .o_wb_adr    (adr),
        .o_wb_we     (we),
        .o_wb_dat    (dat),
        .i_wb_ack    (ack),
        .i_wb_dat    (sdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // d: slave acks in the (d+1)-th strobe cycle; a large d means it never acks in time
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int d, input logic [7:0] fdat, input bit use_f, input bit rogue);
        int sl, nstb;
        bit exp_err;
        logic [3:0] oh;
        logic [31:0] exp_rd;
        sl = int'(a[9:8]);
        nstb = (d + 1 <= TIMEOUT) ? d + 1 : TIMEOUT;
        exp_err = d + 1 > TIMEOUT;
        oh = 4'b0001 << sl;
        exp_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = wd; wstrb = ws;
        for (int c = 1; c <= nstb + 3; c++) begin
            @(negedge clk);
            chk("stb", 32'(stb), (c <= nstb) ? 32'(oh) : 32'd0);
            chk("ready", 32'(ready), 32'(c == nstb + 1));
            chk("err", 32'(err), 32'(c == nstb + 1 && exp_err));
            if (c <= nstb) begin
                chk("adr", 32'(adr), 32'(a[3:2]));
                chk("we", 32'(we), 32'(|ws));
                chk("dat", 32'(dat), 32'(wd[7:0]));
            end
            if (c == nstb + 1) chk("rdata", rdata, exp_rd);
            sdat = $urandom;
            ack = '0;
            if (c == d + 1 && c <= nstb) begin
                if (use_f) sdat[sl*8 +: 8] = fdat;
                ack[sl] = 1'b1;
                exp_rd = (|ws) ? 32'h0 : {24'h0, sdat[sl*8 +: 8]};
            end
            if (rogue && c == 2) ack[sl ^ 2] = 1'b1;
            if (c == nstb + 2) valid = 1'b0;
        end
        ack = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_adr_dat_we", {21'd0, adr, dat, we}, 32'd0);
        rst_n = 1'b1;
        // read from slave 1, write to slave 2
        txn(32'h0200_0100, 32'h0, 4'h0, 1, 8'hA5, 1'b1, 1'b0);
        txn(32'h0200_0204, 32'h0000_003C, 4'h1, 1, 8'h00, 1'b0, 1'b0);
        // miss held for 10 cycles
        @(negedge clk);
        valid = 1'b1; addr = 32'h0000_1000; wstrb = 4'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("miss_stb", 32'(stb), 32'd0);
            chk("miss_ready", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        // timeout, ack exactly on the last allowed cycle, wrong-slave ack
        txn(32'h0200_0300, 32'h0, 4'h0, 1000, 8'h00, 1'b0, 1'b0);
        txn(32'h0200_0108, 32'h0, 4'h0, TIMEOUT - 1, 8'h77, 1'b1, 1'b0);
        txn(32'h0200_0000, 32'h0, 4'h0, 4, 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            txn(32'h0200_0000 | ($urandom & 32'h0000_FFFF), $urandom,
                ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                int'($urandom_range(1, 17)), 8'h00, 1'b0, 1'b0);
        // reset while strobing
        @(negedge clk);
        valid = 1'b1; addr = 32'h0200_0200; wstrb = 4'h0;
        @(negedge clk);
        chk("pre_rst_stb", 32'(stb), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(stb), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(ready), 32'd0);
            chk("post_rst_stb", 32'(stb), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pico2wb_bridge.md
PICO2WB_BRIDGE -- requirements
Module: pico2wb_bridge

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of Wishbone slaves (power of two, max 16).
REQ-002 SHALL have parameter ASIZE, default 2, Wishbone register-address width.
REQ-003 SHALL have parameter DSIZE, default 8, Wishbone data width (1..32).
REQ-004 SHALL have parameter PBASE, default 32'h0200_0000, peripheral window base; window = PBASE[31:16] match.
REQ-005 SHALL have parameter TIMEOUT, default 15, maximum REQ-state cycles without ack.
REQ-006 i_clk  input  1  clock, rising edge.
REQ-007 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_mem_valid  input  1  CPU native-bus request.
REQ-009 i_mem_addr  input  32  CPU byte address.
REQ-010 i_mem_wdata  input  32  CPU write data.
REQ-011 i_mem_wstrb  input  4  write strobes; all zero = read.
REQ-012 o_mem_ready  output  1  one-cycle completion pulse.
REQ-013 o_mem_rdata  output  32  read data, valid while o_mem_ready=1.
REQ-014 o_err  output  1  timeout flag, pulses with o_mem_ready.
REQ-015 o_wb_stb  output  NSLV  one-hot per-slave strobe.
REQ-016 o_wb_adr / o_wb_we / o_wb_dat  output  ASIZE / 1 / DSIZE  shared address, write enable, write data.
REQ-017 i_wb_ack  input  NSLV  per-slave ack; i_wb_dat  input  NSLV*DSIZE  per-slave read data, slave k at [k*DSIZE +: DSIZE].

Function
REQ-018 Hit = i_mem_valid & (i_mem_addr[31:16]==PBASE[31:16]); misses SHALL be ignored (no strobe, no ready).
REQ-019 Slave index = i_mem_addr[8 +: log2(NSLV)]; o_wb_adr = i_mem_addr[ASIZE+1:2]; o_wb_dat = i_mem_wdata[DSIZE-1:0]; o_wb_we = |i_mem_wstrb.
REQ-020 FSM states IDLE, REQ, RESP; IDLE->REQ on hit, registering index, adr, dat, we.
REQ-021 In REQ, o_wb_stb[index] SHALL be 1, all others 0; adr/dat/we SHALL stay stable through the ack cycle inclusive.
REQ-022 REQ->RESP when i_wb_ack[index]=1; acks from unselected slaves SHALL be ignored.
REQ-023 On ack, o_mem_rdata SHALL be zero-extended selected-slave i_wb_dat for reads, 32'h0 for writes.
REQ-024 Strobe SHALL drop in the cycle after ack is seen (single ack per transfer, slave acks one cycle after strobe).
REQ-025 RESP: o_mem_ready=1 for exactly one cycle, then IDLE; a request still valid in RESP SHALL NOT be re-accepted that cycle.
REQ-026 Cycle-level latency with a one-cycle-ack slave: valid sampled T0, stb T1, ack T2, ready T3.
REQ-027 Timeout counter SHALL clear on entering REQ, increment each REQ cycle; at count==TIMEOUT without ack -> RESP with o_mem_rdata=32'hFFFF_FFFF, o_err=1.
REQ-028 Ack and timeout in same cycle: ack SHALL win, o_err=0.
REQ-029 o_err and o_mem_ready SHALL be 0 outside RESP.

Reset
REQ-030 On i_rst_n=0: state IDLE, o_wb_stb=0, o_mem_ready=0, o_err=0, o_mem_rdata=0, o_wb_adr=0, o_wb_dat=0, o_wb_we=0, counter=0.
REQ-031 Reset mid-transfer SHALL abort immediately; no ready pulse after release until a new hit.

Structure
REQ-032 State encoding, PBASE default, and timeout read value 32'hFFFF_FFFF SHALL live in shared package pico_soc_pkg.
REQ-033 Slave-select decode SHALL be sub-module wb_addr_dec (addr in, hit + index out, combinational).

Verification
REQ-034 Read: addr 32'h0200_0100, wstrb 0, slave1 acks with dat 8'hA5 -> stb=4'b0010, ready at T3, rdata 32'h0000_00A5.
REQ-035 Write: addr 32'h0200_0204, wdata 32'h0000_003C, wstrb 4'h1 -> stb=4'b0100, adr=2'b01, we=1, dat=8'h3C, ready at T3.
REQ-036 Miss: addr 32'h0000_1000 valid 10 cycles -> stb stays 0, ready stays 0.
REQ-037 Timeout: slave3 never acks, TIMEOUT=15 -> stb held 15 cycles, then ready=1, err=1, rdata 32'hFFFF_FFFF.
REQ-038 Wrong-slave ack: select slave0, slave2 acks -> ignored; slave0 ack 3 cycles later completes normally.
REQ-039 Reset asserted in REQ -> stb 0 immediately; after release, no ready without new request.
